// File: rtl/ppfifo_stream_arbiter.sv
// rtl/ppfifo_stream_arbiter.sv - round-robin block arbiter from NUM_CH ping-pong FIFOs onto one ppfifo read port
// Define PPFIFO_ARB_FIXED_PRIORITY_EN for lowest-index-first selection instead of round-robin.
module ppfifo_stream_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int USER_COUNT = 1,
  parameter int CH_BITS    = $clog2(NUM_CH)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_CH-1:0]                         i_ch_rdy,
  output logic [NUM_CH-1:0]                         o_ch_act,
  input  logic [NUM_CH*24-1:0]                      i_ch_size,
  input  logic [NUM_CH*(DATA_WIDTH+USER_COUNT)-1:0] i_ch_data,
  output logic [NUM_CH-1:0]                         o_ch_stb,
  output logic                                      o_ppfifo_rdy,
  input  logic                                      i_ppfifo_act,
  output logic [23:0]                               o_ppfifo_size,
  output logic [DATA_WIDTH+USER_COUNT-1:0]          o_ppfifo_data,
  input  logic                                      i_ppfifo_stb,
  output logic [CH_BITS-1:0]                        o_grant_ch,
  output logic                                      o_busy,
  output logic                                      o_short_pulse,
  output logic                                      o_overrun
);

  localparam int WORD_W = DATA_WIDTH + USER_COUNT;

  typedef enum logic [2:0] {IDLE, ACQUIRE, OFFER, BUSY, RELEASE} state_t;

  state_t              r_state;
  logic [CH_BITS-1:0]  r_sel;
  logic [CH_BITS-1:0]  r_ptr;
  logic [23:0]         r_count;

  logic                w_any;
  logic [CH_BITS-1:0]  w_pick;
  logic [23:0]         w_size_sel;
  logic                w_fwd;
  logic                w_over;

  assign o_grant_ch    = r_sel;
  assign o_busy        = (r_state != IDLE);
  assign w_size_sel    = i_ch_size[int'(r_sel)*24 +: 24];
  assign o_ppfifo_data = i_ch_data[int'(r_sel)*WORD_W +: WORD_W];
  assign w_fwd         = (r_state == BUSY) && i_ppfifo_stb && (r_count < o_ppfifo_size);
  assign w_over        = (r_state == BUSY) && i_ppfifo_stb && (r_count >= o_ppfifo_size);

  always_comb begin
    o_ch_stb = '0;
    if (w_fwd) o_ch_stb[r_sel] = 1'b1;
  end

  // Descending scan so the last hit is the first channel in search order.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
`ifdef PPFIFO_ARB_FIXED_PRIORITY_EN
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i_ch_rdy[i]) begin
        w_any  = 1'b1;
        w_pick = CH_BITS'(i);
      end
    end
`else
    for (int i = NUM_CH; i >= 1; i--) begin
      if (i_ch_rdy[(int'(r_ptr) + i) % NUM_CH]) begin
        w_any  = 1'b1;
        w_pick = CH_BITS'((int'(r_ptr) + i) % NUM_CH);
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_sel         <= '0;
      r_ptr         <= CH_BITS'(NUM_CH - 1);
      r_count       <= '0;
      o_ch_act      <= '0;
      o_ppfifo_rdy  <= 1'b0;
      o_ppfifo_size <= '0;
      o_short_pulse <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      o_short_pulse <= 1'b0;
      if (w_fwd)  r_count   <= r_count + 24'd1;
      if (w_over) o_overrun <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_sel    <= w_pick;
            r_ptr    <= w_pick;
            o_ch_act <= {{(NUM_CH-1){1'b0}}, 1'b1} << w_pick;
            r_state  <= ACQUIRE;
          end
        end
        ACQUIRE: begin
          o_ppfifo_size <= w_size_sel;
          r_count       <= '0;
          if (w_size_sel == 24'd0) begin
            r_state <= RELEASE;
          end else begin
            o_ppfifo_rdy <= 1'b1;
            r_state      <= OFFER;
          end
        end
        OFFER: begin
          if (i_ppfifo_act) begin
            o_ppfifo_rdy <= 1'b0;
            r_state      <= BUSY;
          end
        end
        BUSY: begin
          if (!i_ppfifo_act) begin
            o_short_pulse <= (r_count < o_ppfifo_size);
            r_state       <= RELEASE;
          end
        end
        RELEASE: begin
          o_ch_act <= '0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ppfifo_stream_arbiter.sv
// tb/tb_ppfifo_stream_arbiter.sv - randomized self-checking bench for ppfifo_stream_arbiter
// Honours PPFIFO_ARB_FIXED_PRIORITY_EN to match the DUT build.
module tb_ppfifo_stream_arbiter;

  localparam int NUM_CH = 4;
  localparam int DW     = 32;
  localparam int UC     = 1;
  localparam int W      = DW + UC;
  localparam int CB     = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_CH-1:0]     i_ch_rdy = '0;
  logic [NUM_CH-1:0]     o_ch_act;
  logic [NUM_CH*24-1:0]  i_ch_size = '0;
  logic [NUM_CH*W-1:0]   i_ch_data = '0;
  logic [NUM_CH-1:0]     o_ch_stb;
  logic                  o_ppfifo_rdy;
  logic                  i_ppfifo_act = 1'b0;
  logic [23:0]           o_ppfifo_size;
  logic [W-1:0]          o_ppfifo_data;
  logic                  i_ppfifo_stb = 1'b0;
  logic [CB-1:0]         o_grant_ch;
  logic                  o_busy;
  logic                  o_short_pulse;
  logic                  o_overrun;

  int checks = 0;
  int errors = 0;

  int           sizes [NUM_CH];
  logic [W-1:0] words [NUM_CH];
  int           exp_ptr;
  bit           exp_ovr;
  int           last_wait;
  int           last_grant;

  ppfifo_stream_arbiter #(
    .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .USER_COUNT(UC)
  ) dut (
    .clk(clk), .rst(rst),
    .i_ch_rdy(i_ch_rdy), .o_ch_act(o_ch_act),
    .i_ch_size(i_ch_size), .i_ch_data(i_ch_data), .o_ch_stb(o_ch_stb),
    .o_ppfifo_rdy(o_ppfifo_rdy), .i_ppfifo_act(i_ppfifo_act),
    .o_ppfifo_size(o_ppfifo_size), .o_ppfifo_data(o_ppfifo_data),
    .i_ppfifo_stb(i_ppfifo_stb), .o_grant_ch(o_grant_ch), .o_busy(o_busy),
    .o_short_pulse(o_short_pulse), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic pack();
    for (int c = 0; c < NUM_CH; c++) begin
      i_ch_size[c*24 +: 24] = sizes[c][23:0];
      i_ch_data[c*W +: W]   = words[c];
    end
  endtask

  function automatic int next_grant(input logic [NUM_CH-1:0] mask);
    int g;
    g = -1;
`ifdef PPFIFO_ARB_FIXED_PRIORITY_EN
    for (int c = NUM_CH - 1; c >= 0; c--) if (mask[c]) g = c;
`else
    for (int i = NUM_CH; i >= 1; i--) if (mask[(exp_ptr + i) % NUM_CH]) g = (exp_ptr + i) % NUM_CH;
`endif
    return g;
  endfunction

  // Serve one granted block as the downstream reader, issuing nstb strobes.
  task automatic run_block(input int nstb, input bit hold);
    int ch, sz, waited;
    bit got;
    logic [NUM_CH-1:0] oh, exp_stb;
    ch = next_grant(i_ch_rdy);
    sz = (ch >= 0) ? sizes[ch] : 0;
    oh = (ch >= 0) ? (NUM_CH'(1) << ch) : '0;
    got = 0;
    waited = 0;
    while (!got && waited < 20) begin
      @(negedge clk);
      waited++;
      if (o_ch_act != '0) got = 1;
    end
    last_wait  = waited;
    last_grant = ch;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL grant_timeout: no o_ch_act after %0d cycles, expected ch %0d", waited, ch);
      return;
    end
    checks++;
    if (o_ch_act !== oh) begin errors++; $display("FAIL ch_act: got %b want %b", o_ch_act, oh); end
    checks++;
    if (o_grant_ch !== CB'(ch)) begin errors++; $display("FAIL grant_ch: got %0d want %0d", o_grant_ch, ch); end
    exp_ptr = ch;
    @(posedge clk); #1;
    if (!hold) i_ch_rdy = '0;
    @(negedge clk);
    if (sz == 0) begin
      checks++;
      if (o_ppfifo_rdy !== 1'b0 || o_ch_act !== oh || o_busy !== 1'b1) begin
        errors++;
        $display("FAIL zero_release: rdy %b act %b busy %b want 0 %b 1", o_ppfifo_rdy, o_ch_act, o_busy, oh);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (o_ch_act !== '0 || o_busy !== 1'b0 || o_ppfifo_rdy !== 1'b0) begin
        errors++;
        $display("FAIL zero_idle: act %b busy %b rdy %b want 0 0 0", o_ch_act, o_busy, o_ppfifo_rdy);
      end
      return;
    end
    checks++;
    if (o_ppfifo_rdy !== 1'b1) begin errors++; $display("FAIL offer_rdy: got %b want 1", o_ppfifo_rdy); end
    checks++;
    if (o_ppfifo_size !== 24'(sz)) begin errors++; $display("FAIL offer_size: got %0d want %0d", o_ppfifo_size, sz); end
    @(posedge clk); #1;
    i_ppfifo_act = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < nstb; k++) begin
      for (int c = 0; c < NUM_CH; c++) words[c] = {$urandom, $urandom} & {W{1'b1}};
      pack();
      i_ppfifo_stb = 1'b1;
      @(negedge clk);
      exp_stb = (k < sz) ? oh : '0;
      checks++;
      if (o_ch_stb !== exp_stb) begin errors++; $display("FAIL ch_stb[%0d]: got %b want %b", k, o_ch_stb, exp_stb); end
      if (k < sz) begin
        checks++;
        if (o_ppfifo_data !== words[ch]) begin
          errors++;
          $display("FAIL data[%0d]: got %h want %h", k, o_ppfifo_data, words[ch]);
        end
      end
      if (k == 0) begin
        checks++;
        if (o_ppfifo_rdy !== 1'b0) begin errors++; $display("FAIL busy_rdy: got %b want 0", o_ppfifo_rdy); end
      end
      @(posedge clk); #1;
    end
    i_ppfifo_stb = 1'b0;
    i_ppfifo_act = 1'b0;
    if (nstb > sz) exp_ovr = 1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (o_short_pulse !== (nstb < sz)) begin
      errors++;
      $display("FAIL short_pulse: got %b want %b (size %0d strobes %0d)", o_short_pulse, (nstb < sz), sz, nstb);
    end
    checks++;
    if (o_ch_act !== oh) begin errors++; $display("FAIL release_act: got %b want %b", o_ch_act, oh); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (o_ch_act !== '0 || o_busy !== 1'b0 || o_short_pulse !== 1'b0) begin
      errors++;
      $display("FAIL idle_after: act %b busy %b short %b want 0 0 0", o_ch_act, o_busy, o_short_pulse);
    end
    checks++;
    if (o_overrun !== exp_ovr) begin errors++; $display("FAIL overrun: got %b want %b", o_overrun, exp_ovr); end
  endtask

  task automatic test_reset();
    i_ch_rdy = '0;
    i_ppfifo_act = 1'b0;
    i_ppfifo_stb = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (o_ch_act !== '0 || o_ch_stb !== '0 || o_ppfifo_rdy !== 1'b0 || o_ppfifo_size !== 24'd0 ||
        o_grant_ch !== '0 || o_busy !== 1'b0 || o_short_pulse !== 1'b0 || o_overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: act %b stb %b rdy %b size %0d grant %0d busy %b short %b ovr %b",
               o_ch_act, o_ch_stb, o_ppfifo_rdy, o_ppfifo_size, o_grant_ch, o_busy, o_short_pulse, o_overrun);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_ptr = NUM_CH - 1;
    exp_ovr = 0;
  endtask

  task automatic test_single();
    for (int c = 0; c < NUM_CH; c++) sizes[c] = 8;
    pack();
    @(posedge clk); #1;
    i_ch_rdy = 4'b0010;
    run_block(8, 0);
    checks++;
    if (last_wait != 2) begin errors++; $display("FAIL grant_latency: act after %0d cycles want 2", last_wait); end
  endtask

  task automatic test_round_robin();
    for (int c = 0; c < NUM_CH; c++) sizes[c] = 4;
    pack();
    @(posedge clk); #1;
    i_ch_rdy = '1;
    for (int b = 0; b < 8; b++) begin
      run_block(4, b != 7);
      checks++;
`ifdef PPFIFO_ARB_FIXED_PRIORITY_EN
      if (last_grant != 0) begin errors++; $display("FAIL rr_seq[%0d]: got %0d want 0", b, last_grant); end
`else
      if (last_grant != b % NUM_CH) begin errors++; $display("FAIL rr_seq[%0d]: got %0d want %0d", b, last_grant, b % NUM_CH); end
`endif
    end
  endtask

  task automatic test_zero_size();
    sizes[2] = 0;
    pack();
    @(posedge clk); #1;
    i_ch_rdy = 4'b0100;
    run_block(0, 0);
  endtask

  task automatic test_short_and_overrun();
    int ch;
    ch = $urandom_range(0, NUM_CH - 1);
    sizes[ch] = 5;
    pack();
    @(posedge clk); #1;
    i_ch_rdy = NUM_CH'(1) << ch;
    run_block(3, 0);
    ch = $urandom_range(0, NUM_CH - 1);
    sizes[ch] = 5;
    pack();
    @(posedge clk); #1;
    i_ch_rdy = NUM_CH'(1) << ch;
    run_block(6, 0);
  endtask

  task automatic test_reset_mid_block();
    int waited;
    sizes[2] = 6;
    pack();
    @(posedge clk); #1;
    i_ch_rdy = 4'b0100;
    waited = 0;
    while (o_ppfifo_rdy !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
    checks++;
    if (o_ppfifo_rdy !== 1'b1) begin errors++; $display("FAIL mid_offer: rdy %b after %0d cycles", o_ppfifo_rdy, waited); end
    @(posedge clk); #1;
    i_ppfifo_act = 1'b1;
    @(posedge clk); #1;
    repeat (2) begin
      i_ppfifo_stb = 1'b1;
      @(posedge clk); #1;
    end
    i_ppfifo_stb = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (o_ch_act !== '0 || o_ppfifo_rdy !== 1'b0 || o_busy !== 1'b0 || o_short_pulse !== 1'b0 || o_overrun !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: act %b rdy %b busy %b short %b ovr %b want all 0",
               o_ch_act, o_ppfifo_rdy, o_busy, o_short_pulse, o_overrun);
    end
    i_ppfifo_act = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_ptr = NUM_CH - 1;
    exp_ovr = 0;
    run_block(6, 0);
    checks++;
    if (last_grant != 2) begin errors++; $display("FAIL regrant_after_reset: got %0d want 2", last_grant); end
  endtask

  task automatic test_random();
    for (int b = 0; b < 16; b++) begin
      for (int c = 0; c < NUM_CH; c++) sizes[c] = $urandom_range(0, 6);
      pack();
      @(posedge clk); #1;
      i_ch_rdy = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
      run_block($urandom_range(0, 7), 0);
    end
  endtask

  initial begin
    for (int c = 0; c < NUM_CH; c++) begin
      sizes[c] = 0;
      words[c] = '0;
    end
    exp_ptr = NUM_CH - 1;
    exp_ovr = 0;
    test_reset();
    test_single();
    test_reset();
    test_round_robin();
    test_zero_size();
    test_short_and_overrun();
    test_reset_mid_block();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ppfifo_stream_arbiter.md
Name: ppfifo_stream_arbiter

Overview:
Round-robin arbiter that shares one ping-pong FIFO read interface between NUM_CH upstream ping-pong FIFOs. It feeds the single PPFIFO-to-AXI-stream adapter. Grants are whole blocks only: the arbiter activates the chosen upstream FIFO and re-presents it downstream as one ppfifo read port. It tracks strobes per block and releases the upstream FIFO only after the downstream reader drops act.

Parameters:
NUM_CH, 4, number of upstream ppfifo channels (2..8)
DATA_WIDTH, 32, data bits per word
USER_COUNT, 1, sideband user bits carried above the data bits in each word
CH_BITS, $clog2(NUM_CH), width of the channel index (derived; do not override)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
i_ch_rdy  in  NUM_CH  upstream block-ready per channel
o_ch_act  out  NUM_CH  upstream activate, one-hot or zero
i_ch_size  in  NUM_CH*24  upstream block sizes; channel k at [24k+23:24k]
i_ch_data  in  NUM_CH*(DATA_WIDTH+USER_COUNT)  upstream read words, packed by channel
o_ch_stb  out  NUM_CH  upstream read strobe, one-hot or zero
o_ppfifo_rdy  out  1  downstream block available
i_ppfifo_act  in  1  downstream reader active
o_ppfifo_size  out  24  size of the granted block (registered)
o_ppfifo_data  out  DATA_WIDTH+USER_COUNT  selected channel's word (combinational mux)
i_ppfifo_stb  in  1  downstream read strobe
o_grant_ch  out  CH_BITS  index of the current or last granted channel
o_busy  out  1  high in any state other than IDLE
o_short_pulse  out  1  one-cycle pulse: block released with count < size
o_overrun  out  1  sticky: strobe seen after count reached size; cleared only by rst

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, all o_ch_act=0, o_ch_stb=0, o_ppfifo_rdy=0, o_ppfifo_size=0, o_grant_ch=0, round-robin pointer=NUM_CH-1, r_count=0, o_busy=0, o_short_pulse=0, o_overrun=0.
- Reset asserted mid-block: act drops asynchronously; upstream keeps its unread block; no partial-release flag.
- States: IDLE, ACQUIRE, OFFER, BUSY, RELEASE.
- IDLE: if any i_ch_rdy, select the first ready channel searching from pointer+1 with wrap at NUM_CH. Register sel, o_grant_ch, pointer; set o_ch_act[sel]=1; go to ACQUIRE.
- Latency: i_ch_rdy seen in cycle N -> o_ch_act[sel] high in N+1 -> o_ppfifo_rdy high in N+2.
- ACQUIRE (1 cycle): latch i_ch_size[sel] into o_ppfifo_size; r_count=0.
  - If latched size is 0: go to RELEASE; o_ppfifo_rdy stays 0.
  - Otherwise: o_ppfifo_rdy=1; go to OFFER.
- OFFER: hold o_ppfifo_rdy=1 until i_ppfifo_act=1. On that cycle, o_ppfifo_rdy=0 and go to BUSY. There is no timeout.
- BUSY:
  - o_ch_stb[sel] = i_ppfifo_stb & (r_count < o_ppfifo_size), combinational.
  - Each forwarded strobe increments r_count.
  - A strobe while r_count >= size is not forwarded and sets o_overrun.
  - When i_ppfifo_act falls: go to RELEASE. Pulse o_short_pulse if r_count < size.
- RELEASE (1 cycle): o_ch_act[sel]=0, then go to IDLE. The released channel cannot be regranted in this cycle. It becomes eligible again in IDLE at the earliest 1 cycle later.
- i_ch_rdy changes on unselected channels during a grant: ignored until IDLE.
- All channels ready in every cycle: grants rotate 0,1,..,NUM_CH-1,0; no channel is starved.
- o_ppfifo_data = i_ch_data slice of o_grant_ch in all states; it is valid only while in BUSY.
- r_count is 24 bits and cannot wrap, since size <= 2^24-1.

Optional Feature:
PPFIFO_ARB_FIXED_PRIORITY_EN
- Defined: IDLE always selects the lowest-index ready channel; the pointer is unused but still resets.
- Undefined: round-robin selection as above.
- All other timing is identical in both builds.

Test Plan:
- Ch1 only ready, size=8 -> o_ch_act=4'b0010 at N+1, o_ppfifo_rdy at N+2, size=8. Reader issues 8 strobes and drops act -> o_ch_stb[1] pulses 8 times, o_ch_act clears 1 cycle after act falls, o_short_pulse=0.
- All 4 channels held ready, size=4 each, 8 blocks -> o_grant_ch sequence 0,1,2,3,0,1,2,3. With PPFIFO_ARB_FIXED_PRIORITY_EN -> 0,0,0,... (ch0 re-arms).
- Ch2 size=0 -> o_ch_act[2] high 2 cycles, o_ppfifo_rdy never high, o_busy low again after RELEASE.
- Size=5, reader strobes 3 times then drops act -> o_short_pulse=1 for 1 cycle, o_ch_stb[sel] count=3. Size=5 with 6 strobes -> 5 forwarded, o_overrun=1 until rst.
- rst asserted in BUSY after 2 of 6 strobes -> o_ch_act=0 and o_ppfifo_rdy=0 without waiting for a clock edge. After release, the same channel is regranted first with size 6, since the pointer was reset to NUM_CH-1 and ch0 is not ready.
